// File: rtl/snake_stream_pkg.sv
// Shared definitions for the snake-game stream fabric: arbiter FSM states,
// source count and the packet type codes carried in beat byte [7:0].
package snake_stream_pkg;

  localparam int NUM_SRC = 4;

  localparam logic [7:0] PKT_PLAYER = 8'h01;
  localparam logic [7:0] PKT_BULLET = 8'h02;
  localparam logic [7:0] PKT_ENEMY  = 8'h03;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping 3->0, returned as one-hot grant plus its index.
module rr_pick
  import snake_stream_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic [1:0] idx,
  output logic       vld
);

  logic [1:0] cand;

  always_comb begin
    grant = '0;
    idx   = ptr;
    vld   = 1'b0;
    cand  = ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = ptr + 2'(i);
      if (!vld && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        vld         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_arbiter.sv
// Four-source packet arbiter: round-robin grant held for a whole packet,
// pass-through datapath, and a watchdog for sources that stall mid-packet.
module stream_arbiter
  import snake_stream_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,

  input  logic [DATA_W-1:0] i_s_axis_src0_tdata,
  input  logic              i_s_axis_src0_tvalid,
  input  logic              i_s_axis_src0_tlast,
  output logic              o_s_axis_src0_tready,

  input  logic [DATA_W-1:0] i_s_axis_src1_tdata,
  input  logic              i_s_axis_src1_tvalid,
  input  logic              i_s_axis_src1_tlast,
  output logic              o_s_axis_src1_tready,

  input  logic [DATA_W-1:0] i_s_axis_src2_tdata,
  input  logic              i_s_axis_src2_tvalid,
  input  logic              i_s_axis_src2_tlast,
  output logic              o_s_axis_src2_tready,

  input  logic [DATA_W-1:0] i_s_axis_src3_tdata,
  input  logic              i_s_axis_src3_tvalid,
  input  logic              i_s_axis_src3_tlast,
  output logic              o_s_axis_src3_tready,

  output logic [DATA_W-1:0] o_m_axis_tdata,
  output logic              o_m_axis_tvalid,
  output logic              o_m_axis_tlast,
  input  logic              i_m_axis_tready,

  input  logic [3:0]        i_src_en,
  output logic [3:0]        o_grant,
  output logic              o_timeout_err,
  input  logic              i_err_clr
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  arb_state_e  state_q;
  logic [3:0]  grant_q;
  logic [1:0]  gidx_q;
  logic [1:0]  rr_ptr_q;
  logic [15:0] wd_cnt_q;
  logic        timeout_err_q;

  logic [DATA_W-1:0] src_data [NUM_SRC];
  logic [3:0]        src_valid;
  logic [3:0]        src_last;

  logic [3:0]        pick_grant;
  logic [1:0]        pick_idx;
  logic              pick_vld;

  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;
  logic              sel_last;
  logic [15:0]       wd_next;
  logic              pkt_done;
  logic              timeout_hit;

  assign src_data[0] = i_s_axis_src0_tdata;
  assign src_data[1] = i_s_axis_src1_tdata;
  assign src_data[2] = i_s_axis_src2_tdata;
  assign src_data[3] = i_s_axis_src3_tdata;
  assign src_valid   = {i_s_axis_src3_tvalid, i_s_axis_src2_tvalid,
                        i_s_axis_src1_tvalid, i_s_axis_src0_tvalid};
  assign src_last    = {i_s_axis_src3_tlast, i_s_axis_src2_tlast,
                        i_s_axis_src1_tlast, i_s_axis_src0_tlast};

  // Enables only gate new arbitration; an in-flight grant ignores them.
  rr_pick u_rr_pick (
    .req   (src_valid & i_src_en),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .vld   (pick_vld)
  );

  // grant_q is zero outside BUSY, so the AND-OR mux also blanks the idle cycle.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_data  = sel_data | (src_data[i] & {DATA_W{grant_q[i]}});
      sel_valid = sel_valid | (src_valid[i] & grant_q[i]);
      sel_last  = sel_last | (src_last[i] & grant_q[i]);
    end
  end

  assign wd_next     = wd_cnt_q + 16'd1;
  assign pkt_done    = (state_q == ST_BUSY) && sel_valid && i_m_axis_tready && sel_last;
  assign timeout_hit = (state_q == ST_BUSY) && !sel_valid && (wd_next == TIMEOUT_CNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      gidx_q        <= '0;
      rr_ptr_q      <= '0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end else if (i_err_clr) begin
        timeout_err_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          wd_cnt_q <= '0;
          if (pick_vld) begin
            grant_q <= pick_grant;
            gidx_q  <= pick_idx;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (pkt_done || timeout_hit) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= gidx_q + 2'd1;
            wd_cnt_q <= '0;
          end else if (sel_valid) begin
            // Backpressure with data pending is not a stall of the source.
            wd_cnt_q <= '0;
          end else begin
            wd_cnt_q <= wd_next;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign o_s_axis_src0_tready = grant_q[0] & i_m_axis_tready;
  assign o_s_axis_src1_tready = grant_q[1] & i_m_axis_tready;
  assign o_s_axis_src2_tready = grant_q[2] & i_m_axis_tready;
  assign o_s_axis_src3_tready = grant_q[3] & i_m_axis_tready;

  assign o_m_axis_tdata  = sel_data;
  assign o_m_axis_tvalid = sel_valid;
  assign o_m_axis_tlast  = sel_last;
  assign o_grant         = grant_q;
  assign o_timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: arbitration order, packet hold,
// backpressure, watchdog, enables and reset behaviour.
module tb_stream_arbiter;
  import snake_stream_pkg::*;

  localparam int DW = 64;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data [4];
  logic [3:0]    s_valid;
  logic [3:0]    s_last;
  logic [3:0]    s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic [3:0]    src_en;
  logic [3:0]    grant;
  logic          err;
  logic          err_clr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_s_axis_src0_tdata  (s_data[0]),
    .i_s_axis_src0_tvalid (s_valid[0]),
    .i_s_axis_src0_tlast  (s_last[0]),
    .o_s_axis_src0_tready (s_ready[0]),
    .i_s_axis_src1_tdata  (s_data[1]),
    .i_s_axis_src1_tvalid (s_valid[1]),
    .i_s_axis_src1_tlast  (s_last[1]),
    .o_s_axis_src1_tready (s_ready[1]),
    .i_s_axis_src2_tdata  (s_data[2]),
    .i_s_axis_src2_tvalid (s_valid[2]),
    .i_s_axis_src2_tlast  (s_last[2]),
    .o_s_axis_src2_tready (s_ready[2]),
    .i_s_axis_src3_tdata  (s_data[3]),
    .i_s_axis_src3_tvalid (s_valid[3]),
    .i_s_axis_src3_tlast  (s_last[3]),
    .o_s_axis_src3_tready (s_ready[3]),
    .o_m_axis_tdata       (m_data),
    .o_m_axis_tvalid      (m_valid),
    .o_m_axis_tlast       (m_last),
    .i_m_axis_tready      (m_ready),
    .i_src_en             (src_en),
    .o_grant              (grant),
    .o_timeout_err        (err),
    .i_err_clr            (err_clr)
  );

  function automatic logic [DW-1:0] mk(int s, int b);
    return {16'hBEEF, 8'(s), 8'(b), 24'h5A5A5A, PKT_BULLET};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 4'hF; s_last = 4'hF; m_ready = 1'b1;
    src_en = 4'hF; err_clr = 1'b0;
    for (int i = 0; i < 4; i++) s_data[i] = mk(i, 0);
    tick;
    total++;
    if ({grant, s_ready, m_valid, err} !== 10'b0) begin
      bad++; $display("FAIL reset_state: got %b want %b", {grant, s_ready, m_valid, err}, 10'b0);
    end
    tick; tick;
    total++;
    if ({grant, s_ready, m_valid, err} !== 10'b0) begin
      bad++; $display("FAIL reset_hold: got %b want %b", {grant, s_ready, m_valid, err}, 10'b0);
    end
    s_valid = 4'h0; rst_n = 1'b1;
    tick; tick;
    total++;
    if ({grant, m_valid} !== 5'b0) begin
      bad++; $display("FAIL idle_no_req: got %b want %b", {grant, m_valid}, 5'b0);
    end
  endtask

  task automatic test_two_src();
    s_valid = 4'b0101; s_last = 4'b0000;
    s_data[0] = mk(0, 0); s_data[2] = mk(2, 0);
    #1;
    total++;
    if ({grant, s_ready, m_valid} !== 9'b0) begin
      bad++; $display("FAIL two_arb_latency: got %b want %b", {grant, s_ready, m_valid}, 9'b0);
    end
    tick;
    for (int b = 0; b < 3; b++) begin
      s_data[0] = mk(0, b); s_last[0] = (b == 2);
      #1;
      total++;
      if ({grant, s_ready, m_valid, m_last} !== {4'b0001, 4'b0001, 1'b1, b == 2} || m_data !== mk(0, b)) begin
        bad++; $display("FAIL two_src0_beat%0d: got %b/%h want %b/%h", b,
          {grant, s_ready, m_valid, m_last}, m_data, {4'b0001, 4'b0001, 1'b1, b == 2}, mk(0, b));
      end
      tick;
    end
    s_valid[0] = 1'b0;
    #1;
    total++;
    if ({grant, s_ready, m_valid} !== 9'b0) begin
      bad++; $display("FAIL two_idle_gap: got %b want %b", {grant, s_ready, m_valid}, 9'b0);
    end
    tick;
    for (int b = 0; b < 3; b++) begin
      s_data[2] = mk(2, b); s_last[2] = (b == 2);
      #1;
      total++;
      if ({grant, s_ready, m_valid, m_last} !== {4'b0100, 4'b0100, 1'b1, b == 2} || m_data !== mk(2, b)) begin
        bad++; $display("FAIL two_src2_beat%0d: got %b/%h want %b/%h", b,
          {grant, s_ready, m_valid, m_last}, m_data, {4'b0100, 4'b0100, 1'b1, b == 2}, mk(2, b));
      end
      tick;
    end
    // rr_ptr must now be 3: src3 beats src0
    s_valid = 4'b1001; s_last = 4'b1001; s_data[0] = mk(0, 9); s_data[3] = mk(3, 9);
    tick;
    total++;
    if (grant !== 4'b1000 || m_data !== mk(3, 9)) begin
      bad++; $display("FAIL two_rr_ptr3: got %b/%h want %b/%h", grant, m_data, 4'b1000, mk(3, 9));
    end
    tick;
    s_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    s_valid = 4'hF; s_last = 4'hF;
    for (int i = 0; i < 4; i++) s_data[i] = mk(i, 7);
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if ({grant, m_valid} !== 5'b0) begin
        bad++; $display("FAIL rr_idle%0d: got %b want %b", k, {grant, m_valid}, 5'b0);
      end
      tick;
      total++;
      if ({grant, m_valid, m_last} !== {4'(1 << (k % 4)), 2'b11} || m_data !== mk(k % 4, 7)) begin
        bad++; $display("FAIL rr_grant%0d: got %b/%h want %b/%h", k, {grant, m_valid, m_last}, m_data,
          {4'(1 << (k % 4)), 2'b11}, mk(k % 4, 7));
      end
      tick;
    end
    s_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    int viol;
    s_valid = 4'b0010; s_last = 4'b0000; s_data[1] = mk(1, 0);
    tick;
    total++;
    if (grant !== 4'b0010 || m_data !== mk(1, 0)) begin
      bad++; $display("FAIL bp_grant: got %b/%h want %b/%h", grant, m_data, 4'b0010, mk(1, 0));
    end
    tick;
    s_data[1] = mk(1, 1); m_ready = 1'b0;
    viol = 0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (grant !== 4'b0010 || s_ready !== 4'b0000 || m_valid !== 1'b1 || err !== 1'b0 || m_data !== mk(1, 1))
        viol++;
      tick;
    end
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL bp_hold: got %0d bad cycles want 0", viol);
    end
    m_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      s_data[1] = mk(1, b); s_last[1] = (b == 3);
      #1;
      total++;
      if ({grant, s_ready, m_last} !== {4'b0010, 4'b0010, b == 3} || m_data !== mk(1, b)) begin
        bad++; $display("FAIL bp_beat%0d: got %b/%h want %b/%h", b, {grant, s_ready, m_last}, m_data,
          {4'b0010, 4'b0010, b == 3}, mk(1, b));
      end
      tick;
    end
    s_valid = 4'b0000;
    #1;
    total++;
    if ({grant, err} !== 5'b0) begin
      bad++; $display("FAIL bp_done: got %b want %b", {grant, err}, 5'b0);
    end
  endtask

  task automatic test_timeout();
    int viol;
    s_valid = 4'b1000; s_last = 4'b0000; s_data[3] = mk(3, 0);
    tick;
    total++;
    if (grant !== 4'b1000) begin
      bad++; $display("FAIL to_grant3: got %b want %b", grant, 4'b1000);
    end
    tick;
    s_valid = 4'b0000;
    viol = 0;
    for (int k = 1; k < TO; k++) begin
      tick;
      if (grant !== 4'b1000 || err !== 1'b0) viol++;
    end
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL to_early: got %0d bad cycles want 0", viol);
    end
    tick;
    total++;
    if ({grant, err} !== 5'b00001) begin
      bad++; $display("FAIL to_fire: got %b want %b", {grant, err}, 5'b00001);
    end
    s_valid = 4'b1001; s_last = 4'b1000; s_data[0] = mk(0, 0);
    tick;
    total++;
    if ({grant, err} !== 5'b00011) begin
      bad++; $display("FAIL to_next_src0: got %b want %b", {grant, err}, 5'b00011);
    end
    tick;
    s_valid = 4'b0000; err_clr = 1'b1;
    tick;
    total++;
    if ({grant, err} !== 5'b00010) begin
      bad++; $display("FAIL to_clear: got %b want %b", {grant, err}, 5'b00010);
    end
    for (int k = 2; k < TO; k++) tick;
    tick;
    total++;
    if ({grant, err} !== 5'b00001) begin
      bad++; $display("FAIL to_set_wins: got %b want %b", {grant, err}, 5'b00001);
    end
    tick;
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL to_clear2: got %b want %b", err, 1'b0);
    end
    err_clr = 1'b0;
  endtask

  task automatic test_enable();
    int viol;
    src_en = 4'b1101; s_valid = 4'b0010; s_last = 4'b0010; s_data[1] = mk(1, 5);
    viol = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if ({grant, s_ready, m_valid} !== 9'b0) viol++;
      tick;
    end
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL en_masked: got %0d bad cycles want 0", viol);
    end
    s_valid = 4'b0011; s_last[0] = 1'b0; s_data[0] = mk(0, 0);
    tick;
    for (int b = 0; b < 3; b++) begin
      s_data[0] = mk(0, b); s_last[0] = (b == 2);
      if (b == 1) src_en = 4'hF;
      #1;
      total++;
      if ({grant, s_ready, m_last} !== {4'b0001, 4'b0001, b == 2} || m_data !== mk(0, b)) begin
        bad++; $display("FAIL en_src0_beat%0d: got %b/%h want %b/%h", b, {grant, s_ready, m_last}, m_data,
          {4'b0001, 4'b0001, b == 2}, mk(0, b));
      end
      tick;
    end
    s_valid = 4'b0010;
    tick;
    total++;
    if (grant !== 4'b0010 || m_data !== mk(1, 5)) begin
      bad++; $display("FAIL en_src1_after: got %b/%h want %b/%h", grant, m_data, 4'b0010, mk(1, 5));
    end
    tick;
    s_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    s_valid = 4'b0100; s_last = 4'b0000; s_data[2] = mk(2, 0);
    tick;
    total++;
    if (grant !== 4'b0100) begin
      bad++; $display("FAIL rst_pre_grant: got %b want %b", grant, 4'b0100);
    end
    tick;
    s_data[2] = mk(2, 1); rst_n = 1'b0;
    #1;
    total++;
    if ({grant, s_ready, m_valid} !== 9'b0) begin
      bad++; $display("FAIL rst_async: got %b want %b", {grant, s_ready, m_valid}, 9'b0);
    end
    tick;
    rst_n = 1'b1;
    #1;
    total++;
    if (grant !== 4'b0000) begin
      bad++; $display("FAIL rst_release_idle: got %b want %b", grant, 4'b0000);
    end
    tick;
    total++;
    if (grant !== 4'b0100 || m_data !== mk(2, 1)) begin
      bad++; $display("FAIL rst_regrant: got %b/%h want %b/%h", grant, m_data, 4'b0100, mk(2, 1));
    end
    s_last[2] = 1'b1;
    tick;
    s_valid = 4'b0000;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1; s_valid = 4'b1001; s_last = 4'b1001;
    s_data[0] = mk(0, 3); s_data[3] = mk(3, 3);
    tick;
    total++;
    if (grant !== 4'b0001 || m_data !== mk(0, 3)) begin
      bad++; $display("FAIL rst_ptr_zero: got %b/%h want %b/%h", grant, m_data, 4'b0001, mk(0, 3));
    end
    tick;
    s_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_two_src();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, 64, beat width.
REQ-002 SHALL have parameter TIMEOUT, 255, max consecutive idle cycles of the granted source mid-packet (1..65535).
REQ-003 SHALL have port i_clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_s_axis_srcN_tdata  in  DATA_W, for N=0..3, source N beat data; byte [7:0] carries the packet type.
REQ-006 SHALL have ports i_s_axis_srcN_tvalid  in  1  and i_s_axis_srcN_tlast  in  1, for N=0..3, source N valid and last.
REQ-007 SHALL have ports o_s_axis_srcN_tready  out  1, for N=0..3, source N ready.
REQ-008 SHALL have ports o_m_axis_tdata  out  DATA_W, o_m_axis_tvalid  out  1, o_m_axis_tlast  out  1: merged stream to the packet-type router.
REQ-009 SHALL have port i_m_axis_tready  in  1  downstream ready.
REQ-010 SHALL have port i_src_en  in  4  per-source arbitration enable.
REQ-011 SHALL have port o_grant  out  4  one-hot current grant, 0 when idle.
REQ-012 SHALL have ports o_timeout_err  out  1 (sticky) and i_err_clr  in  1 (synchronous clear).

Function
REQ-013 SHALL implement FSM states IDLE and BUSY.
REQ-014 IDLE: all o_s_axis_srcN_tready=0, o_m_axis_tvalid=0; if any (srcN_tvalid & i_src_en[N]), register grant to the first requester at or after rr_ptr (wrapping 3->0) and go to BUSY next cycle (1-cycle arbitration latency).
REQ-015 BUSY: o_m_axis_tdata/tvalid/tlast SHALL be combinational copies of the granted source; o_s_axis_srcG_tready=i_m_axis_tready; non-granted readies=0.
REQ-016 Grant SHALL be held for the whole packet; beat accepted (tvalid&tready) with tlast=1 -> IDLE, rr_ptr=G+1 mod 4.
REQ-017 Throughput: one beat per cycle while granted source valid and downstream ready; no beat dropped or duplicated; one idle cycle between packets.
REQ-018 i_src_en changes SHALL affect only the next arbitration, never an in-flight packet.
REQ-019 Watchdog: in BUSY, a counter SHALL increment each cycle granted tvalid=0, reset to 0 on granted tvalid=1; on reaching TIMEOUT -> IDLE, set o_timeout_err, rr_ptr=G+1; downstream backpressure (tvalid=1, tready=0) SHALL NOT count.
REQ-020 o_timeout_err SHALL be cleared by i_err_clr unless a new timeout occurs the same cycle (set wins).
REQ-021 Single-beat packet (tlast on first beat) SHALL complete in BUSY in one cycle when ready.
REQ-022 No requester or all disabled: stay IDLE, rr_ptr unchanged.
REQ-023 Data, tlast and tvalid SHALL never be modified; packet type inspection is the router's job.

Reset
REQ-024 On i_rst_n=0 (async): state=IDLE, o_grant=0, rr_ptr=0, watchdog=0, o_timeout_err=0, all readies and o_m_axis_tvalid=0.
REQ-025 Reset mid-packet SHALL abandon the packet; after release, arbitration restarts from source 0.

Structure
REQ-026 A shared package snake_stream_pkg SHALL hold the state enum, NUM_SRC=4, and packet type constants PKT_PLAYER=8'h01, PKT_BULLET=8'h02, PKT_ENEMY=8'h03.
REQ-027 The round-robin picker SHALL be a combinational sub-module rr_pick (4-bit request, 2-bit pointer -> one-hot grant, valid).

Verification
REQ-028 Src0 and src2 both valid in IDLE, rr_ptr=0, 3-beat packets -> src0 granted, 3 beats out, then src2 after one idle cycle, rr_ptr=3.
REQ-029 All four sources continuously valid, 1-beat packets, tready=1 -> grants 0,1,2,3,0 in order, each packet every 2 cycles.
REQ-030 Src1 granted, downstream tready=0 for 400 cycles mid-packet -> no timeout; packet completes intact when tready returns.
REQ-031 Src3 granted, drops tvalid after beat 1 with TIMEOUT=8 -> IDLE exactly 8 cycles later, o_timeout_err=1, next grant from src0; i_err_clr clears it.
REQ-032 i_src_en=4'b1101 with src1 valid only -> no grant; setting bit1 mid-packet of src0 -> src0 packet unaffected.
REQ-033 Assert i_rst_n=0 in BUSY mid-packet -> o_grant=0, readies=0 immediately; after release, src2 alone valid -> granted after one cycle.
